// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch-stage types and constants
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_FETCH        = 2'd0,
        ST_WAIT_DISCARD = 2'd1,
        ST_HOLD         = 2'd2
    } fetch_state_t;

    localparam logic [15:0] PC_INC = 16'd2;

    function automatic logic [15:0] align_pc(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch FSM: request handshake, stall hold, redirect discard
module fetch_ctrl
    import fetch_stage_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic jump_in,
    input  logic stall_in,
    input  logic imem_ack,
    input  logic valid_out,
    output logic imem_req,
    output logic accept,
    output logic clear_valid,
    output logic jump_now,
    output logic save_target,
    output logic resume_target
);

    fetch_state_t state, state_next;
    logic         run;

    // run keeps imem_req low until the first edge after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_FETCH;
            run   <= 1'b0;
        end else begin
            state <= state_next;
            run   <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        clear_valid   = 1'b0;
        jump_now      = 1'b0;
        save_target   = 1'b0;
        resume_target = 1'b0;
        imem_req      = run && (state != ST_HOLD);

        case (state)
            ST_FETCH: begin
                if (!run) begin
                    if (jump_in) begin
                        jump_now    = 1'b1;
                        clear_valid = 1'b1;
                    end
                end else if (jump_in) begin
                    clear_valid = 1'b1;
                    if (imem_ack) begin
                        jump_now = 1'b1;
                    end else begin
                        save_target = 1'b1;
                        state_next  = ST_WAIT_DISCARD;
                    end
                end else if (stall_in && valid_out) begin
                    // the returned word cannot be delivered; it is refetched after the stall
                    if (imem_ack)
                        state_next = ST_HOLD;
                end else if (imem_ack) begin
                    accept = 1'b1;
                end else if (!stall_in) begin
                    clear_valid = 1'b1;
                end
            end
            ST_WAIT_DISCARD: begin
                if (imem_ack) begin
                    state_next = ST_FETCH;
                    if (jump_in)
                        jump_now = 1'b1;
                    else
                        resume_target = 1'b1;
                end else if (jump_in) begin
                    save_target = 1'b1;
                end
            end
            ST_HOLD: begin
                if (jump_in || !stall_in) begin
                    jump_now    = jump_in;
                    clear_valid = 1'b1;
                    state_next  = ST_FETCH;
                end
            end
            default: state_next = ST_FETCH;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, memory request and output registers
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jump_in,
    input  logic [15:0] new_pc,
    input  logic        stall_in,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] pc_out,
    output logic [15:0] ir_out,
    output logic [15:0] pcp2_out,
    output logic        valid_out
);

    logic [15:0] pc;
    logic [15:0] target;
    logic        accept, clear_valid, jump_now, save_target, resume_target;

    fetch_ctrl u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .jump_in      (jump_in),
        .stall_in     (stall_in),
        .imem_ack     (imem_ack),
        .valid_out    (valid_out),
        .imem_req     (imem_req),
        .accept       (accept),
        .clear_valid  (clear_valid),
        .jump_now     (jump_now),
        .save_target  (save_target),
        .resume_target(resume_target)
    );

    assign imem_addr = pc;

    // pc stays on the outstanding address during a discard; the redirect waits in target
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= RESET_PC;
            target    <= 16'h0000;
            pc_out    <= 16'h0000;
            ir_out    <= 16'h0000;
            pcp2_out  <= 16'h0000;
            valid_out <= 1'b0;
        end else begin
            if (jump_now)
                pc <= align_pc(new_pc);
            else if (resume_target)
                pc <= target;
            else if (accept)
                pc <= pc + PC_INC;

            if (save_target)
                target <= align_pc(new_pc);

            if (accept) begin
                pc_out    <= pc;
                ir_out    <= imem_rdata;
                pcp2_out  <= pc + PC_INC;
                valid_out <= 1'b1;
            end else if (clear_valid) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed table-driven bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        jump_in;
    logic [15:0] new_pc;
    logic        stall_in;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] pc_out;
    logic [15:0] ir_out;
    logic [15:0] pcp2_out;
    logic        valid_out;

    fetch_stage #(.RESET_PC(16'h0010)) dut (
        .clk       (clk),
        .reset     (reset),
        .jump_in   (jump_in),
        .new_pc    (new_pc),
        .stall_in  (stall_in),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .pc_out    (pc_out),
        .ir_out    (ir_out),
        .pcp2_out  (pcp2_out),
        .valid_out (valid_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        jmp;
        logic [15:0] npc;
        logic        stl;
        logic        ack;
        logic [15:0] rd;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_vld;
        logic [15:0] e_pc;
        logic [15:0] e_ir;
        logic [15:0] e_p2;
    } vec_t;

    localparam int NVEC = 26;
    vec_t tv [NVEC];
    int   n_vec;
    int   n_bad;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic e_req, input logic [15:0] e_addr,
                             input logic e_vld, input logic chk_data, input logic [15:0] e_pc,
                             input logic [15:0] e_ir, input logic [15:0] e_p2);
        n_vec++;
        check({tag, ".imem_req"}, {15'd0, imem_req}, {15'd0, e_req});
        check({tag, ".imem_addr"}, imem_addr, e_addr);
        check({tag, ".valid_out"}, {15'd0, valid_out}, {15'd0, e_vld});
        if (chk_data) begin
            check({tag, ".pc_out"}, pc_out, e_pc);
            check({tag, ".ir_out"}, ir_out, e_ir);
            check({tag, ".pcp2_out"}, pcp2_out, e_p2);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        //          rst jmp npc       stl ack rd        req addr      vld pc        ir        pcp2
        tv[0]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0010, 1'b0,16'h0000,16'h0000,16'h0000};
        tv[1]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0010, 1'b0,16'h0000,16'h0000,16'h0000};
        tv[2]  = '{1'b1,1'b0,16'h0000,1'b0,1'b1,16'hC010, 1'b1,16'h0010, 1'b0,16'h0000,16'h0000,16'h0000};
        tv[3]  = '{1'b1,1'b0,16'h0000,1'b0,1'b1,16'hC012, 1'b1,16'h0012, 1'b1,16'h0010,16'hC010,16'h0012};
        tv[4]  = '{1'b1,1'b0,16'h0000,1'b1,1'b1,16'hC014, 1'b1,16'h0014, 1'b1,16'h0012,16'hC012,16'h0014};
        tv[5]  = '{1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,16'h0014, 1'b1,16'h0012,16'hC012,16'h0014};
        tv[6]  = '{1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,16'h0014, 1'b1,16'h0012,16'hC012,16'h0014};
        tv[7]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0014, 1'b1,16'h0012,16'hC012,16'h0014};
        tv[8]  = '{1'b1,1'b0,16'h0000,1'b0,1'b1,16'hC014, 1'b1,16'h0014, 1'b0,16'h0000,16'h0000,16'h0000};
        tv[9]  = '{1'b1,1'b1,16'h0101,1'b0,1'b1,16'hC016, 1'b1,16'h0016, 1'b1,16'h0014,16'hC014,16'h0016};
        tv[10] = '{1'b1,1'b0,16'h0000,1'b0,1'b1,16'hC100, 1'b1,16'h0100, 1'b0,16'h0000,16'h0000,16'h0000};
        tv[11] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0102, 1'b1,16'h0100,16'hC100,16'h0102};
        tv[12] = '{1'b1,1'b1,16'h0200,1'b0,1'b0,16'h0000, 1'b1,16'h0102, 1'b0,16'h0000,16'h0000,16'h0000};
        tv[13] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0102, 1'b0,16'h0000,16'h0000,16'h0000};
        tv[14] = '{1'b1,1'b0,16'h0000,1'b0,1'b1,16'hC102, 1'b1,16'h0102, 1'b0,16'h0000,16'h0000,16'h0000};
        tv[15] = '{1'b1,1'b0,16'h0000,1'b0,1'b1,16'hC200, 1'b1,16'h0200, 1'b0,16'h0000,16'h0000,16'h0000};
        tv[16] = '{1'b1,1'b1,16'hFFFF,1'b0,1'b1,16'hC202, 1'b1,16'h0202, 1'b1,16'h0200,16'hC200,16'h0202};
        tv[17] = '{1'b1,1'b0,16'h0000,1'b0,1'b1,16'hCFFE, 1'b1,16'hFFFE, 1'b0,16'h0000,16'h0000,16'h0000};
        tv[18] = '{1'b1,1'b0,16'h0000,1'b0,1'b1,16'hC000, 1'b1,16'h0000, 1'b1,16'hFFFE,16'hCFFE,16'h0000};
        tv[19] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0002, 1'b1,16'h0000,16'hC000,16'h0002};
        tv[20] = '{1'b1,1'b1,16'h0300,1'b0,1'b0,16'h0000, 1'b1,16'h0002, 1'b0,16'h0000,16'h0000,16'h0000};
        tv[21] = '{1'b1,1'b1,16'h0400,1'b0,1'b0,16'h0000, 1'b1,16'h0002, 1'b0,16'h0000,16'h0000,16'h0000};
        tv[22] = '{1'b1,1'b0,16'h0000,1'b0,1'b1,16'hC002, 1'b1,16'h0002, 1'b0,16'h0000,16'h0000,16'h0000};
        tv[23] = '{1'b1,1'b0,16'h0000,1'b0,1'b1,16'hC400, 1'b1,16'h0400, 1'b0,16'h0000,16'h0000,16'h0000};
        tv[24] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0402, 1'b1,16'h0400,16'hC400,16'h0402};
        tv[25] = '{1'b1,1'b1,16'h0500,1'b0,1'b0,16'h0000, 1'b1,16'h0402, 1'b0,16'h0000,16'h0000,16'h0000};

        reset      = 1'b0;
        jump_in    = 1'b0;
        new_pc     = 16'h0000;
        stall_in   = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            reset      = tv[i].rst;
            jump_in    = tv[i].jmp;
            new_pc     = tv[i].npc;
            stall_in   = tv[i].stl;
            imem_ack   = tv[i].ack;
            imem_rdata = tv[i].rd;
            #1;
            check_all($sformatf("vec%0d", i), tv[i].e_req, tv[i].e_addr, tv[i].e_vld,
                      tv[i].e_vld || !tv[i].rst, tv[i].e_pc, tv[i].e_ir, tv[i].e_p2);
            @(negedge clk);
        end

        // reset asserted while a discarded request is outstanding
        jump_in  = 1'b0;
        imem_ack = 1'b0;
        #1;
        check_all("wd_before_rst", 1'b1, 16'h0402, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        #2 reset = 1'b0;
        #1;
        check_all("wd_async_rst", 1'b0, 16'h0010, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all("rst_release", 1'b0, 16'h0010, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 16'hC010;
        #1;
        check_all("restart_req", 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        imem_rdata = 16'hC012;
        #1;
        check_all("restart_deliver", 1'b1, 16'h0012, 1'b1, 1'b1, 16'h0010, 16'hC010, 16'h0012);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
